// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
//   Shared definitions for the ALU arbiter: ALU function codes, result flag
//   codes, the arbiter FSM state type and a helper that classifies func codes.
//   No ports; imported by rr_arbiter and alu_arbiter.
// -----------------------------------------------------------------------------
package alu_pkg;

    localparam int DATA_W = 32;
    localparam int FUNC_W = 4;
    localparam int FLAG_W = 2;

    // ALU function codes. FUNC_NONE is what the ALU sees while idle.
    localparam logic [FUNC_W-1:0] FUNC_NONE = 4'd0;
    localparam logic [FUNC_W-1:0] ADD       = 4'd1;
    localparam logic [FUNC_W-1:0] SUB       = 4'd2;
    localparam logic [FUNC_W-1:0] AND       = 4'd3;
    localparam logic [FUNC_W-1:0] OR        = 4'd4;
    localparam logic [FUNC_W-1:0] XOR       = 4'd5;
    localparam logic [FUNC_W-1:0] NOT       = 4'd6;
    localparam logic [FUNC_W-1:0] SLA       = 4'd7;
    localparam logic [FUNC_W-1:0] SRA       = 4'd8;
    localparam logic [FUNC_W-1:0] SRL       = 4'd9;

    // Result flag codes as produced by the ALU.
    localparam logic [FLAG_W-1:0] FLAG_NONE = 2'b00;
    localparam logic [FLAG_W-1:0] FLAG_NEG  = 2'b01;
    localparam logic [FLAG_W-1:0] FLAG_ZERO = 2'b11;
    localparam logic [FLAG_W-1:0] FLAG_POS  = 2'b10;

    // Arbiter FSM states.
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    // True for func codes the ALU implements (ADD..SRL).
    function automatic logic is_legal_func(input logic [FUNC_W-1:0] func);
        return (func >= ADD) && (func <= SRL);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
//   Purely combinational round-robin picker. Grants the first asserted request
//   at or after the pointer, wrapping around past the highest index.
// Ports
//   i_req        in   NUM_REQ   request vector
//   i_ptr        in   PTR_W     index with highest priority this round
//   o_grant      out  NUM_REQ   one-hot grant (all zero when no request)
//   o_grant_idx  out  PTR_W     binary index of the granted requester
//   o_any        out  1         at least one request present
// -----------------------------------------------------------------------------
module rr_arbiter
    import alu_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int PTR_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [PTR_W-1:0]   i_ptr,
    output logic [NUM_REQ-1:0] o_grant,
    output logic [PTR_W-1:0]   o_grant_idx,
    output logic               o_any
);

    int w_idx;

    always_comb begin
        // NOTE: every output of a combinational block gets a default before
        // any conditional assignment; otherwise a latch is inferred.
        o_grant     = '0;
        o_grant_idx = '0;
        o_any       = 1'b0;
        w_idx       = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            // Walk the ring starting at the pointer; first hit wins.
            w_idx = int'(i_ptr) + k;
            if (w_idx >= NUM_REQ) begin
                w_idx = w_idx - NUM_REQ;
            end
            if (!o_any && i_req[w_idx]) begin
                o_any          = 1'b1;
                o_grant[w_idx] = 1'b1;
                o_grant_idx    = PTR_W'(w_idx);
            end
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// -----------------------------------------------------------------------------
// alu_arbiter
//   Shares one registered 32-bit ALU between NUM_REQ requesters. Round-robin
//   arbitration, one operation in flight, valid/ready on request and response.
// Ports
//   clk        in   1            rising-edge clock
//   reset      in   1            asynchronous, active-low
//   req_valid  in   NUM_REQ      per-requester operation valid
//   req_ready  out  NUM_REQ      one-cycle accept pulse to the winner
//   req_func   in   4*NUM_REQ    func code, slice i for requester i
//   req_a      in   32*NUM_REQ   operand 1, slice i for requester i
//   req_b      in   32*NUM_REQ   operand 2, slice i for requester i
//   rsp_valid  out  NUM_REQ      one-hot, held until the owner's rsp_ready
//   rsp_ready  in   NUM_REQ      response consume strobe
//   rsp_data   out  32           result
//   rsp_flag   out  2            01 negative, 11 zero, 10 positive
//   rsp_err    out  1            illegal func code
//   alu_inp1   out  32           ALU operand 1
//   alu_inp2   out  32           ALU operand 2
//   alu_func   out  4            ALU func, 0 when idle
//   alu_out    in   32           ALU result
//   alu_flag   in   2            ALU flag (derived from registered result)
// -----------------------------------------------------------------------------
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int NUM_REQ  = 2,
    parameter int RES_LAT  = 1,
    parameter int FLAG_LAT = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_REQ-1:0]      req_valid,
    output logic [NUM_REQ-1:0]      req_ready,
    input  logic [4*NUM_REQ-1:0]    req_func,
    input  logic [32*NUM_REQ-1:0]   req_a,
    input  logic [32*NUM_REQ-1:0]   req_b,
    output logic [NUM_REQ-1:0]      rsp_valid,
    input  logic [NUM_REQ-1:0]      rsp_ready,
    output logic [31:0]             rsp_data,
    output logic [1:0]              rsp_flag,
    output logic                    rsp_err,
    output logic [31:0]             alu_inp1,
    output logic [31:0]             alu_inp2,
    output logic [3:0]              alu_func,
    input  logic [31:0]             alu_out,
    input  logic [1:0]              alu_flag
);

    localparam int PTR_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(FLAG_LAT + 1);

    // FSM and arbitration state
    state_t                 r_state;
    logic [PTR_W-1:0]       r_ptr;
    logic [NUM_REQ-1:0]     r_owner_oh;
    logic [PTR_W-1:0]       r_owner_idx;

    // Latched copy of the granted request
    logic [FUNC_W-1:0]      r_func;
    logic [DATA_W-1:0]      r_a;
    logic [DATA_W-1:0]      r_b;
    logic                   r_err;

    // Latency counter for the ALU pipeline
    logic [CNT_W-1:0]       r_cnt;

    // Registered outputs
    logic [NUM_REQ-1:0]     r_req_ready;
    logic [NUM_REQ-1:0]     r_rsp_valid;
    logic [DATA_W-1:0]      r_rsp_data;
    logic [FLAG_W-1:0]      r_rsp_flag;
    logic                   r_rsp_err;
    logic [DATA_W-1:0]      r_alu_inp1;
    logic [DATA_W-1:0]      r_alu_inp2;
    logic [FUNC_W-1:0]      r_alu_func;

    // Arbiter result and the winner's request fields
    logic [NUM_REQ-1:0]     w_grant;
    logic [PTR_W-1:0]       w_grant_idx;
    logic                   w_grant_any;
    logic [FUNC_W-1:0]      w_func_sel;
    logic [DATA_W-1:0]      w_a_sel;
    logic [DATA_W-1:0]      w_b_sel;
    logic                   w_rsp_hs;
    logic                   w_capture_out;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_rr_arbiter (
        .i_req       (req_valid),
        .i_ptr       (r_ptr),
        .o_grant     (w_grant),
        .o_grant_idx (w_grant_idx),
        .o_any       (w_grant_any)
    );

    // Select the winner's slices with a one-hot mux.
    always_comb begin
        w_func_sel = '0;
        w_a_sel    = '0;
        w_b_sel    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_grant[i]) begin
                w_func_sel = req_func[i*FUNC_W +: FUNC_W];
                w_a_sel    = req_a[i*DATA_W +: DATA_W];
                w_b_sel    = req_b[i*DATA_W +: DATA_W];
            end
        end
    end

    // Only the current owner's rsp_ready completes the response.
    assign w_rsp_hs = |(rsp_ready & r_rsp_valid);

    // The counter is loaded with FLAG_LAT when the ALU inputs go out and
    // reaches 0 on the edge where alu_flag is valid; alu_out is valid on the
    // edge where RES_LAT cycles have elapsed by the same measure.
    assign w_capture_out = (FLAG_LAT - int'(r_cnt)) == RES_LAT;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_ptr       <= '0;
            r_owner_oh  <= '0;
            r_owner_idx <= '0;
            r_func      <= FUNC_NONE;
            r_a         <= '0;
            r_b         <= '0;
            r_err       <= 1'b0;
            r_cnt       <= '0;
            r_req_ready <= '0;
            r_rsp_valid <= '0;
            r_rsp_data  <= '0;
            r_rsp_flag  <= FLAG_NONE;
            r_rsp_err   <= 1'b0;
            r_alu_inp1  <= '0;
            r_alu_inp2  <= '0;
            r_alu_func  <= FUNC_NONE;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples pre-edge values regardless of statement order.
            r_req_ready <= '0;
            case (r_state)
                S_IDLE: begin
                    if (w_grant_any) begin
                        r_req_ready <= w_grant;
                        r_owner_oh  <= w_grant;
                        r_owner_idx <= w_grant_idx;
                        r_func      <= w_func_sel;
                        r_a         <= w_a_sel;
                        r_b         <= w_b_sel;
                        r_err       <= !is_legal_func(w_func_sel);
                        r_state     <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (r_err) begin
                        // Illegal op never reaches the ALU; a single WAIT
                        // cycle returns the error response two cycles after
                        // the accept.
                        r_cnt <= '0;
                    end else begin
                        r_alu_inp1 <= r_a;
                        r_alu_inp2 <= r_b;
                        r_alu_func <= r_func;
                        r_cnt      <= CNT_W'(FLAG_LAT);
                    end
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    if (!r_err && w_capture_out) begin
                        r_rsp_data <= alu_out;
                    end
                    if (r_cnt == '0) begin
                        r_alu_func  <= FUNC_NONE;
                        r_rsp_valid <= r_owner_oh;
                        if (r_err) begin
                            r_rsp_data <= '0;
                            r_rsp_flag <= FLAG_ZERO;
                            r_rsp_err  <= 1'b1;
                        end else begin
                            r_rsp_flag <= alu_flag;
                            r_rsp_err  <= 1'b0;
                        end
                        r_state <= S_RESP;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                S_RESP: begin
                    if (w_rsp_hs) begin
                        r_rsp_valid <= '0;
                        r_ptr       <= (r_owner_idx == PTR_W'(NUM_REQ - 1)) ?
                                       '0 : r_owner_idx + PTR_W'(1);
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign req_ready = r_req_ready;
    assign rsp_valid = r_rsp_valid;
    assign rsp_data  = r_rsp_data;
    assign rsp_flag  = r_rsp_flag;
    assign rsp_err   = r_rsp_err;
    assign alu_inp1  = r_alu_inp1;
    assign alu_inp2  = r_alu_inp2;
    assign alu_func  = r_alu_func;

endmodule
